// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer
// Divides the 512 Hz DIV falling edge into the APU frame-step clock enables:
// length (256 Hz), sweep (128 Hz) and envelope (64 Hz), each a one-clock pulse.
// Optional build macro APU_FRAME_SEQ_FAST_EN adds the test_fast port and the
// FAST_PERIOD parameter. When test_fast=1, an internal counter replaces the
// DIV edge as the frame-step source.
module apu_frame_sequencer
`ifdef APU_FRAME_SEQ_FAST_EN
  #(parameter int FAST_PERIOD = 16)
`endif
  (
  input  logic       apuv_4mhz,
  input  logic       apu_reset,
  input  logic       apu_on,
  input  logic       div_bit,
`ifdef APU_FRAME_SEQ_FAST_EN
  input  logic       test_fast,
`endif
  output logic [2:0] step,
  output logic       frame_tick,
  output logic       len_tick,
  output logic       sweep_tick,
  output logic       env_tick
);

  logic       div_q_reg;
  logic       div_edge;
  logic       frame_edge;
  logic [2:0] step_reg,  step_next;
  logic       frame_reg, frame_next;
  logic       len_reg,   len_next;
  logic       sweep_reg, sweep_next;
  logic       env_reg,   env_next;

  // Delayed copy of div_bit; keeps tracking even while powered off so no stale edge survives power-up
  always_ff @(posedge apuv_4mhz or posedge apu_reset) begin
    if (apu_reset) div_q_reg <= 1'b0;
    else           div_q_reg <= div_bit;
  end

  assign div_edge = div_q_reg & ~div_bit;

`ifdef APU_FRAME_SEQ_FAST_EN
  localparam int             FCW       = $clog2(FAST_PERIOD);
  localparam logic [FCW-1:0] FAST_LAST = FCW'(FAST_PERIOD - 1);

  logic [FCW-1:0] fast_cnt_reg, fast_cnt_next;

  // Fast-mode counter: runs 0..FAST_PERIOD-1 only while test mode and power are both on
  always_comb begin
    fast_cnt_next = '0;
    if (test_fast && apu_on && (fast_cnt_reg != FAST_LAST))
      fast_cnt_next = fast_cnt_reg + 1'b1;
  end

  // Fast counter register
  always_ff @(posedge apuv_4mhz or posedge apu_reset) begin
    if (apu_reset) fast_cnt_reg <= '0;
    else           fast_cnt_reg <= fast_cnt_next;
  end

  assign frame_edge = test_fast ? (fast_cnt_reg == FAST_LAST) : div_edge;
`else
  assign frame_edge = div_edge;
`endif

  // Step decode: ticks are decoded from the step being executed, then the step advances
  always_comb begin
    step_next  = step_reg;
    frame_next = 1'b0;
    len_next   = 1'b0;
    sweep_next = 1'b0;
    env_next   = 1'b0;
    if (!apu_on) begin
      // power off overrides any coincident edge
      step_next = 3'd0;
    end else if (frame_edge) begin
      frame_next = 1'b1;
      len_next   = ~step_reg[0];
      sweep_next = (step_reg == 3'd2) || (step_reg == 3'd6);
      env_next   = (step_reg == 3'd7);
      step_next  = step_reg + 3'd1;
    end
  end

  // Step and tick registers; reset drops every pulse immediately
  always_ff @(posedge apuv_4mhz or posedge apu_reset) begin
    if (apu_reset) begin
      step_reg  <= 3'd0;
      frame_reg <= 1'b0;
      len_reg   <= 1'b0;
      sweep_reg <= 1'b0;
      env_reg   <= 1'b0;
    end else begin
      step_reg  <= step_next;
      frame_reg <= frame_next;
      len_reg   <= len_next;
      sweep_reg <= sweep_next;
      env_reg   <= env_next;
    end
  end

  assign step       = step_reg;
  assign frame_tick = frame_reg;
  assign len_tick   = len_reg;
  assign sweep_tick = sweep_reg;
  assign env_tick   = env_reg;

endmodule
